fhazard_sb: RTL and testbench

- Parametrised FPU hazard unit: stall, forwarding and register scoreboard for the FP pipeline.
- Generalises single-cycle decode/execute hazard detection to NSRC source operands.
- Adds a busy-bit scoreboard for multi-cycle FP ops (fdivsqrt): tracks outstanding long-latency writes, stalls RAW/WAW hazards against them, and forwards their writeback result.
- Sits beside the FPU datapath; drives FPUStallD into the hazard unit and the per-source forwarding muxes in Execute.

---
 rtl/fhazard_sb.sv | 143 ++++++++++++++
 tb/tb_fhazard_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fhazard_sb.sv
// FP hazard unit: Decode stall, Execute forward selects and a busy-bit scoreboard for long-latency FP ops.
// Stall and forward selects are combinational (0 cycles); the scoreboard updates on the rising edge; FPUStallD is the only backpressure.
module fhazard_sb #(
    parameter  int NSRC    = 3,
    parameter  int NREG    = 32,
    parameter  int MAXLONG = 2,
    parameter  int SCW     = 16,
    localparam int ADRW    = $clog2(NREG),
    localparam int CW      = $clog2(MAXLONG + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSRC*ADRW-1:0] AdrD,
    input  logic [NSRC-1:0]      SrcEnD,
    input  logic [ADRW-1:0]      RdD,
    input  logic                 FRegWriteD,
    input  logic                 LongD,
    input  logic [NSRC*ADRW-1:0] AdrE,
    input  logic [ADRW-1:0]      RdE,
    input  logic [ADRW-1:0]      RdM,
    input  logic [ADRW-1:0]      RdW,
    input  logic                 FRegWriteE,
    input  logic                 FRegWriteM,
    input  logic                 FRegWriteW,
    input  logic [1:0]           FResSelM,
    input  logic                 LongIssueE,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 LongDoneW,
    input  logic [ADRW-1:0]      LongRdW,
    output logic                 FPUStallD,
    output logic [NSRC*2-1:0]    ForwardE,
    output logic [NREG-1:0]      BusyVec,
    output logic [CW-1:0]        LongCnt,
    output logic [SCW-1:0]       StallCnt
);

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_LONG = 2'b11;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXLONG);

    logic [NREG-1:0] busy_vec_q, busy_vec_d;
    logic [CW-1:0]   long_cnt_q, long_cnt_d;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;

    logic            stall_raw_e;
    logic            stall_sb;
    logic            stall_cap;
    logic            issue;
    logic [ADRW-1:0] adr_dec;
    logic [ADRW-1:0] adr_exe;
    logic [NSRC*2-1:0] fwd_sel;

    // Decode stall terms; the scoreboard is read from the flop, so a bit being cleared this cycle still stalls.
    always_comb begin
        stall_raw_e = 1'b0;
        stall_sb    = 1'b0;
        adr_dec     = '0;
        for (int i = 0; i < NSRC; i++) begin
            adr_dec = AdrD[i*ADRW +: ADRW];
            if (SrcEnD[i] && FRegWriteE && (adr_dec == RdE)) begin
                stall_raw_e = 1'b1;
            end
            if (SrcEnD[i] && busy_vec_q[adr_dec]) begin
                stall_sb = 1'b1;
            end
        end
        if (FRegWriteD && busy_vec_q[RdD]) begin
            stall_sb = 1'b1;
        end
        stall_cap = LongD && (long_cnt_q == CNT_MAX);
    end

    assign FPUStallD = stall_raw_e | stall_sb | stall_cap;

    // A Memory-stage match owns the source even when its result is not ready yet.
    always_comb begin
        fwd_sel = '0;
        adr_exe = '0;
        for (int i = 0; i < NSRC; i++) begin
            adr_exe = AdrE[i*ADRW +: ADRW];
            if (FRegWriteM && (adr_exe == RdM)) begin
                fwd_sel[i*2 +: 2] = (FResSelM == 2'b00) ? FWD_M : FWD_RF;
            end else if (LongDoneW && (adr_exe == LongRdW)) begin
                fwd_sel[i*2 +: 2] = FWD_LONG;
            end else if (FRegWriteW && (adr_exe == RdW)) begin
                fwd_sel[i*2 +: 2] = FWD_W;
            end
        end
    end

    assign ForwardE = fwd_sel;

    assign issue = LongIssueE & FRegWriteE & ~StallE & ~FlushE;

    always_comb begin
        busy_vec_d = busy_vec_q;
        if (LongDoneW) begin
            busy_vec_d[LongRdW] = 1'b0;
        end
        // Applied after the clear so a new issue to the same register keeps it busy.
        if (issue) begin
            busy_vec_d[RdE] = 1'b1;
        end

        long_cnt_d = long_cnt_q;
        if (issue && !LongDoneW && (long_cnt_q != CNT_MAX)) begin
            long_cnt_d = long_cnt_q + CW'(1);
        end else if (!issue && LongDoneW && (long_cnt_q != '0)) begin
            long_cnt_d = long_cnt_q - CW'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (FPUStallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec_q  <= '0;
            long_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_vec_q  <= busy_vec_d;
            long_cnt_q  <= long_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign BusyVec  = busy_vec_q;
    assign LongCnt  = long_cnt_q;
    assign StallCnt = stall_cnt_q;

    long_done_without_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n) LongDoneW |-> (long_cnt_q != '0));

    long_issue_over_capacity: assert property (
        @(posedge clk) disable iff (!reset_n) (issue && !LongDoneW) |-> (long_cnt_q != CNT_MAX));

endmodule

// File: tb/tb_fhazard_sb.sv
// Directed vectors push expected values into a queue stamped with the cycle; a negedge monitor pops and compares.
module tb_fhazard_sb;

    localparam int NSRC = 3, NREG = 32, ADRW = 5, MAXLONG = 2, CW = 2, SCW = 16;
    localparam int K_STALL = 0, K_FWD = 1, K_BUSY = 2, K_CNT = 3, K_SC = 4, K_BVEC = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NSRC*ADRW-1:0] AdrD, AdrE;
    logic [NSRC-1:0]      SrcEnD;
    logic [ADRW-1:0]      RdD, RdE, RdM, RdW, LongRdW;
    logic                 FRegWriteD, LongD, FRegWriteE, FRegWriteM, FRegWriteW;
    logic                 LongIssueE, StallE, FlushE, LongDoneW;
    logic [1:0]           FResSelM;
    logic                 FPUStallD;
    logic [NSRC*2-1:0]    ForwardE;
    logic [NREG-1:0]      BusyVec;
    logic [CW-1:0]        LongCnt;
    logic [SCW-1:0]       StallCnt;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_sc = 0;
    bit   stim_done = 1'b0;

    fhazard_sb #(.NSRC(NSRC), .NREG(NREG), .MAXLONG(MAXLONG), .SCW(SCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .AdrD(AdrD), .SrcEnD(SrcEnD), .RdD(RdD), .FRegWriteD(FRegWriteD), .LongD(LongD),
        .AdrE(AdrE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .FRegWriteE(FRegWriteE), .FRegWriteM(FRegWriteM), .FRegWriteW(FRegWriteW),
        .FResSelM(FResSelM), .LongIssueE(LongIssueE), .StallE(StallE), .FlushE(FlushE),
        .LongDoneW(LongDoneW), .LongRdW(LongRdW),
        .FPUStallD(FPUStallD), .ForwardE(ForwardE), .BusyVec(BusyVec),
        .LongCnt(LongCnt), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int kind, int idx);
        case (kind)
            K_STALL: return {31'b0, FPUStallD};
            K_FWD:   return {30'b0, ForwardE[idx*2 +: 2]};
            K_BUSY:  return {31'b0, BusyVec[idx]};
            K_CNT:   return 32'(LongCnt);
            K_SC:    return 32'(StallCnt);
            default: return BusyVec;
        endcase
    endfunction

    // Monitor: sole owner of the check/failure counters and of the summary line.
    initial begin
        exp_t e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (reset_n && LongDoneW && FRegWriteW && (LongRdW == RdW)) begin
                failures++;
                $display("FAIL long_w_collision: LongDoneW and FRegWriteW both write f%0d at cycle %0d", RdW, cyc);
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                got = actual(e.kind, e.idx);
                checks++;
                if (e.cyc != cyc) begin
                    failures++;
                    $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
                end else if (got !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h at cycle %0d", e.name, got, e.val, cyc);
                end
            end
            if (stim_done || cyc > 80000) begin
                checks++;
                if (!stim_done || q.size() != 0) begin
                    failures++;
                    $display("FAIL run_complete: stim_done=%0d pending=%0d required stim_done=1 pending=0", stim_done, q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        AdrD = '0; SrcEnD = '0; RdD = '0; FRegWriteD = 1'b0; LongD = 1'b0;
        AdrE = '0; RdE = '0; RdM = '0; RdW = '0;
        FRegWriteE = 1'b0; FRegWriteM = 1'b0; FRegWriteW = 1'b0; FResSelM = 2'b00;
        LongIssueE = 1'b0; StallE = 1'b0; FlushE = 1'b0; LongDoneW = 1'b0; LongRdW = '0;
    endtask

    task automatic sad(int i, int a);
        AdrD[i*ADRW +: ADRW] = ADRW'(a);
    endtask

    task automatic sae(int i, int a);
        AdrE[i*ADRW +: ADRW] = ADRW'(a);
    endtask

    task automatic push(string n, int k, int idx, logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.name = n; e.kind = k; e.idx = idx; e.val = v;
        q.push_back(e);
    endtask

    // Expected stall this cycle plus the stall count accumulated over earlier cycles.
    task automatic chk(string n, bit st);
        push(n, K_STALL, 0, 32'(st));
        push({n, "_stallcnt"}, K_SC, 0, 32'(exp_sc));
        if (st) exp_sc++;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        push("reset_busy", K_BVEC, 0, 32'h0);
        push("reset_cnt", K_CNT, 0, 0);
        chk("reset", 1'b0);

        step(); reset_n = 1'b1; idle();
        RdE = 5; FRegWriteE = 1'b1; sad(0, 5); SrcEnD = 3'b001;
        chk("e_raw_src0", 1'b1);
        step(); SrcEnD = 3'b000;
        chk("e_raw_noen", 1'b0);
        step(); sad(2, 5); SrcEnD = 3'b100;
        chk("e_raw_src2", 1'b1);
        step(); FRegWriteE = 1'b0;
        chk("e_raw_nowrite", 1'b0);

        step(); idle(); LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 7;
        chk("issue7", 1'b0);
        push("issue7_cnt_before", K_CNT, 0, 0);
        push("issue7_busy_before", K_BUSY, 7, 0);
        step(); idle(); sad(1, 7); SrcEnD = 3'b010;
        chk("sb_raw", 1'b1);
        push("sb_busy7", K_BUSY, 7, 1);
        push("sb_cnt1", K_CNT, 0, 1);
        step(); LongDoneW = 1'b1; LongRdW = 7; sae(1, 7);
        chk("sb_raw_done_cycle", 1'b1);
        push("fwd_long", K_FWD, 1, 3);
        push("fwd_none", K_FWD, 0, 0);
        step(); LongDoneW = 1'b0;
        chk("sb_released", 1'b0);
        push("sb_busy7_clear", K_BUSY, 7, 0);
        push("sb_cnt0", K_CNT, 0, 0);
        push("fwd_long_gone", K_FWD, 1, 0);

        step(); idle(); sae(2, 3); RdM = 3; FRegWriteM = 1'b1; FResSelM = 2'b00; RdW = 3; FRegWriteW = 1'b1;
        chk("fwd_phase", 1'b0);
        push("fwd_m", K_FWD, 2, 2);
        step(); FResSelM = 2'b01;
        chk("fwd_phase2", 1'b0);
        push("fwd_m_not_ready", K_FWD, 2, 0);
        step(); FRegWriteM = 1'b0;
        chk("fwd_phase3", 1'b0);
        push("fwd_w", K_FWD, 2, 1);

        step(); idle(); LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 1;
        chk("issue1", 1'b0);
        step(); RdE = 2; LongD = 1'b1;
        chk("cap_below", 1'b0);
        push("cap_cnt1", K_CNT, 0, 1);
        step(); idle(); LongD = 1'b1;
        chk("cap_full", 1'b1);
        push("cap_cnt2", K_CNT, 0, 2);
        push("cap_busy1", K_BUSY, 1, 1);
        push("cap_busy2", K_BUSY, 2, 1);
        step(); idle(); LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 9; FlushE = 1'b1;
        chk("issue_flushed", 1'b0);
        step(); idle(); LongDoneW = 1'b1; LongRdW = 1; RdM = 1; FRegWriteM = 1'b1; sae(0, 1);
        chk("m_over_long", 1'b0);
        push("flush_no_busy9", K_BUSY, 9, 0);
        push("flush_cnt2", K_CNT, 0, 2);
        push("fwd_m_over_long", K_FWD, 0, 2);

        step(); idle(); LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 4; LongDoneW = 1'b1; LongRdW = 4;
        chk("set_clear_same", 1'b0);
        push("done1_cnt1", K_CNT, 0, 1);
        push("busy4_before", K_BUSY, 4, 0);
        step(); idle();
        push("set_wins_busy4", K_BUSY, 4, 1);
        push("cnt_issue_and_done", K_CNT, 0, 1);
        push("busy2_before_done", K_BUSY, 2, 1);
        LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 9; LongDoneW = 1'b1; LongRdW = 2;
        chk("issue9_done2", 1'b0);
        step(); idle(); RdD = 9; FRegWriteD = 1'b1;
        chk("waw", 1'b1);
        push("waw_busy9", K_BUSY, 9, 1);
        push("done2_busy2", K_BUSY, 2, 0);
        push("issue_done_cnt1", K_CNT, 0, 1);
        step(); FRegWriteD = 1'b0; LongIssueE = 1'b1; FRegWriteE = 1'b1; RdE = 11; StallE = 1'b1;
        chk("waw_nowrite", 1'b0);
        step(); idle();
        chk("pre_reset", 1'b0);
        push("stalle_no_busy11", K_BUSY, 11, 0);
        push("busy_before_reset", K_BVEC, 0, 32'h0000_0210);
        push("cnt_before_reset", K_CNT, 0, 1);

        step(); reset_n = 1'b0; exp_sc = 0;
        push("async_reset_busy", K_BVEC, 0, 32'h0);
        push("async_reset_cnt", K_CNT, 0, 0);
        chk("async_reset", 1'b0);
        step(); reset_n = 1'b1;
        chk("post_reset", 1'b0);

        for (int k = 0; k < 65539; k++) begin
            step();
            if (k == 0) begin
                RdE = 5; FRegWriteE = 1'b1; sad(0, 5); SrcEnD = 3'b001;
                push("sat_stall", K_STALL, 0, 1);
                push("sat_start", K_SC, 0, 0);
            end
            if (k == 65534) push("sat_below_max", K_SC, 0, 32'd65534);
            if (k == 65535) push("sat_reach_max", K_SC, 0, 32'd65535);
            if (k == 65538) push("sat_hold_max", K_SC, 0, 32'd65535);
        end
        step(); idle();
        push("sat_idle_stall", K_STALL, 0, 0);
        push("sat_idle_cnt", K_SC, 0, 32'd65535);
        step();
        stim_done = 1'b1;
    end

endmodule
